// File: rtl/pcs_rx_sync_pkg.sv
// Shared 1000BASE-X receive constants: sync state encodings, comma patterns and 8b/10b sub-block tables.
package pcs_rx_sync_pkg;

  localparam int DEF_GOOD_CGS_MAX = 3;
  localparam int DEF_CNT_W        = 2;

  typedef enum logic [12:0] {
    ST_LOS  = 13'h0001,
    ST_CD1  = 13'h0002,
    ST_CD2  = 13'h0004,
    ST_CD3  = 13'h0008,
    ST_AS1  = 13'h0010,
    ST_AS2  = 13'h0020,
    ST_SA1  = 13'h0040,
    ST_SA2  = 13'h0080,
    ST_SA2A = 13'h0100,
    ST_SA3  = 13'h0200,
    ST_SA3A = 13'h0400,
    ST_SA4  = 13'h0800,
    ST_SA4A = 13'h1000
  } state_t;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;
  localparam logic [9:0] CG_K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] CG_D16_2_POS = 10'b1001000101;

  // abcdei sub-blocks legal when the running disparity entering the code-group is negative
  function automatic logic six_ok_neg(input logic [5:0] s);
    return s inside {6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                     6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                     6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                     6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                     6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                     6'b011110, 6'b101011, 6'b001111};
  endfunction

  function automatic logic six_ok_pos(input logic [5:0] s);
    return s inside {6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                     6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                     6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                     6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                     6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                     6'b100001, 6'b010100, 6'b110000};
  endfunction

  // Returns {valid, is_k} for a legal abcdei followed by fghj, given disparity after abcdei.
  function automatic logic [1:0] tail_check(input logic [5:0] s, input logic mid_pos,
                                            input logic [3:0] f);
    logic k28, kx, a7_data, p7, a7, plain;
    k28 = (s == 6'b001111) || (s == 6'b110000);
    kx  = s inside {6'b111010, 6'b110110, 6'b101110, 6'b011110,
                    6'b000101, 6'b001001, 6'b010001, 6'b100001};
    a7_data = mid_pos ? (s inside {6'b110100, 6'b101100, 6'b011100})
                      : (s inside {6'b100011, 6'b010011, 6'b001011});
    p7    = mid_pos ? (f == 4'b0001) : (f == 4'b1110);
    a7    = mid_pos ? (f == 4'b1000) : (f == 4'b0111);
    plain = mid_pos ? (f inside {4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110})
                    : (f inside {4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110});
    return {plain || (a7 && (k28 || kx || a7_data)) || (p7 && !k28 && !a7_data),
            k28 || (a7 && kx)};
  endfunction

endpackage

// File: rtl/pcs_rx_sync_classify.sv
// Combinational code-group classifier: comma, valid data and cgbad, checked against both disparities.
module pcs_cg_classify
  import pcs_rx_sync_pkg::*;
(
  input  logic [9:0] cg,
  input  logic       rx_even,
  output logic       comma,
  output logic       is_d,
  output logic       cgbad
);

  logic [5:0] six;
  logic [3:0] four;
  logic [1:0] res_neg, res_pos;
  logic       valid_neg, valid_pos, valid;

  assign six  = cg[9:4];
  assign four = cg[3:0];

  assign comma = (cg[9:3] == COMMA_POS) || (cg[9:3] == COMMA_NEG);

  // Disparity after abcdei: a 4-ones block from RD- flips to RD+, a 2-ones block from RD+ flips to RD-.
  assign res_neg = tail_check(six, $countones(six) == 4, four);
  assign res_pos = tail_check(six, $countones(six) != 2, four);

  assign valid_neg = six_ok_neg(six) && res_neg[1];
  assign valid_pos = six_ok_pos(six) && res_pos[1];
  assign valid     = valid_neg || valid_pos;

  assign is_d  = (valid_neg && !res_neg[0]) || (valid_pos && !res_pos[0]);
  assign cgbad = !valid || (comma && rx_even);

endmodule

// File: rtl/pcs_rx_sync.sv
// 1000BASE-X PCS receive synchronization: acquires comma alignment, tracks parity, flags sync.
// LOS: hunting comma | CD1..3: comma seen, expect data | AS1..2: acquiring, await odd comma
// SA1: synced | SAn: n-1 bad strikes | SAnA: counting good groups back toward SA(n-1)
module pcs_rx_sync
  import pcs_rx_sync_pkg::*;
#(
  parameter int GOOD_CGS_MAX = DEF_GOOD_CGS_MAX,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       signal_detect,
  input  logic [9:0] PUDI,
  output logic [9:0] SUDI,
  output logic       rx_even,
  output logic       code_sync_status
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] good_cgs, good_cgs_nxt;
  logic             comma, is_d, cgbad, cggood, at_max;
  logic             even_nxt, sync_nxt;

  pcs_cg_classify u_classify (
    .cg      (PUDI),
    .rx_even (rx_even),
    .comma   (comma),
    .is_d    (is_d),
    .cgbad   (cgbad)
  );

  assign cggood = !cgbad;
  assign at_max = (good_cgs == CNT_W'(GOOD_CGS_MAX));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOS:  if (comma) state_nxt = ST_CD1;
      ST_CD1:  state_nxt = is_d ? ST_AS1 : ST_LOS;
      ST_CD2:  state_nxt = is_d ? ST_AS2 : ST_LOS;
      ST_CD3:  state_nxt = is_d ? ST_SA1 : ST_LOS;
      ST_AS1:  if (!rx_even && comma) state_nxt = ST_CD2;
               else if (cgbad)        state_nxt = ST_LOS;
      ST_AS2:  if (!rx_even && comma) state_nxt = ST_CD3;
               else if (cgbad)        state_nxt = ST_LOS;
      ST_SA1:  if (cgbad) state_nxt = ST_SA2;
      ST_SA2:  state_nxt = cggood ? ST_SA2A : ST_SA3;
      ST_SA3:  state_nxt = cggood ? ST_SA3A : ST_SA4;
      ST_SA4:  state_nxt = cggood ? ST_SA4A : ST_LOS;
      ST_SA2A: if (cgbad) state_nxt = ST_SA3;
               else if (at_max) state_nxt = ST_SA1;
      ST_SA3A: if (cgbad) state_nxt = ST_SA4;
               else if (at_max) state_nxt = ST_SA2;
      ST_SA4A: if (cgbad) state_nxt = ST_LOS;
               else if (at_max) state_nxt = ST_SA3;
      default: state_nxt = ST_LOS;
    endcase
    if (!signal_detect) state_nxt = ST_LOS;
  end

  // Every edge re-enters a state, so parity toggles even on self-loops.
  always_comb begin
    good_cgs_nxt = good_cgs;
    if (state_nxt inside {ST_SA2, ST_SA3, ST_SA4})
      good_cgs_nxt = '0;
    else if (state_nxt inside {ST_SA2A, ST_SA3A, ST_SA4A})
      good_cgs_nxt = at_max ? good_cgs : good_cgs + CNT_W'(1);
    even_nxt = (state_nxt inside {ST_CD1, ST_CD2, ST_CD3}) ? 1'b1 : !rx_even;
    sync_nxt = state_nxt inside {ST_SA1, ST_SA2, ST_SA2A, ST_SA3, ST_SA3A, ST_SA4, ST_SA4A};
  end

  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state            <= ST_LOS;
      good_cgs         <= '0;
      rx_even          <= 1'b0;
      code_sync_status <= 1'b0;
      SUDI             <= 10'h000;
    end else begin
      state            <= state_nxt;
      good_cgs         <= good_cgs_nxt;
      rx_even          <= even_nxt;
      code_sync_status <= sync_nxt;
      SUDI             <= PUDI;
    end
  end

endmodule

// File: tb/tb_pcs_rx_sync.sv
// Directed bench for pcs_rx_sync: reset, acquisition, loss, recovery, odd comma, signal loss, reset.
module tb_pcs_rx_sync;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset;
  logic       signal_detect;
  logic [9:0] PUDI;
  logic [9:0] SUDI;
  logic       rx_even;
  logic       code_sync_status;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b1001000101;
  localparam logic [9:0] BAD  = 10'h000;

  always #5 GTX_CLK = ~GTX_CLK;

  pcs_rx_sync dut (
    .GTX_CLK          (GTX_CLK),
    .mr_main_reset    (mr_main_reset),
    .signal_detect    (signal_detect),
    .PUDI             (PUDI),
    .SUDI             (SUDI),
    .rx_even          (rx_even),
    .code_sync_status (code_sync_status)
  );

  task automatic step(input logic [9:0] cg);
    PUDI = cg;
    @(posedge GTX_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    mr_main_reset = 1'b1;
    signal_detect = 1'b1;
    PUDI          = D162;

    // reset with idles
    step(D162);
    step(D162);
    chk("rst_status", {9'd0, code_sync_status}, 10'd0);
    chk("rst_even",   {9'd0, rx_even},          10'd0);
    chk("rst_sudi",   SUDI,                     10'h000);

    // acquisition: K/D pairs, sync after 6th edge
    mr_main_reset = 1'b0;
    step(K285);
    chk("acq_e1_status", {9'd0, code_sync_status}, 10'd0);
    chk("acq_e1_even",   {9'd0, rx_even},          10'd1);
    step(D162);
    step(K285);
    step(D162);
    step(K285);
    chk("acq_e5_status", {9'd0, code_sync_status}, 10'd0);
    step(D162);
    chk("acq_e6_status", {9'd0, code_sync_status}, 10'd1);
    chk("acq_e6_even",   {9'd0, rx_even},          10'd0);
    chk("acq_e6_sudi",   SUDI,                     D162);
    step(K285);
    chk("sa1_k_sudi",    SUDI,                     K285);
    chk("sa1_k_even",    {9'd0, rx_even},          10'd1);
    step(D162);
    chk("sa1_d_even",    {9'd0, rx_even},          10'd0);
    step(K285);
    chk("sa1_k2_even",   {9'd0, rx_even},          10'd1);
    step(D162);

    // loss: four invalid groups
    step(BAD);
    chk("loss_b1", {9'd0, code_sync_status}, 10'd1);
    step(BAD);
    chk("loss_b2", {9'd0, code_sync_status}, 10'd1);
    step(BAD);
    chk("loss_b3", {9'd0, code_sync_status}, 10'd1);
    step(BAD);
    chk("loss_b4", {9'd0, code_sync_status}, 10'd0);
    chk("loss_sudi", SUDI, BAD);

    // restart from CD1: five more groups reach SA1
    step(K285);
    chk("re_cd1_even",   {9'd0, rx_even},          10'd1);
    chk("re_cd1_status", {9'd0, code_sync_status}, 10'd0);
    step(D162);
    step(K285);
    step(D162);
    step(K285);
    chk("re_cd3_status", {9'd0, code_sync_status}, 10'd0);
    step(D162);
    chk("re_sa1_status", {9'd0, code_sync_status}, 10'd1);

    // recovery: one bad then four good
    step(BAD);
    chk("rec_sa2",      {9'd0, code_sync_status}, 10'd1);
    chk("rec_sa2_even", {9'd0, rx_even},          10'd1);
    for (int i = 0; i < 4; i++) begin
      step(D162);
      chk("rec_good_status", {9'd0, code_sync_status}, 10'd1);
    end
    chk("rec_sa1_even", {9'd0, rx_even}, 10'd1);

    // comma at even position from SA1 counts as bad: three more bad groups reach LOS
    step(K285);
    chk("odd_k_status", {9'd0, code_sync_status}, 10'd1);
    step(BAD);
    chk("odd_b1", {9'd0, code_sync_status}, 10'd1);
    step(BAD);
    chk("odd_b2", {9'd0, code_sync_status}, 10'd1);
    step(BAD);
    chk("odd_b3", {9'd0, code_sync_status}, 10'd0);

    // reacquire, then drop signal_detect for one cycle
    step(K285);
    step(D162);
    step(K285);
    step(D162);
    step(K285);
    step(D162);
    chk("sd_pre_status", {9'd0, code_sync_status}, 10'd1);
    signal_detect = 1'b0;
    step(D162);
    chk("sd_drop_status", {9'd0, code_sync_status}, 10'd0);
    chk("sd_drop_even",   {9'd0, rx_even},          10'd1);
    signal_detect = 1'b1;

    // reach AS2, then reset mid-acquisition
    step(K285);
    step(D162);
    step(K285);
    step(D162);
    chk("as2_status", {9'd0, code_sync_status}, 10'd0);
    mr_main_reset = 1'b1;
    step(K285);
    chk("midrst_status", {9'd0, code_sync_status}, 10'd0);
    chk("midrst_even",   {9'd0, rx_even},          10'd0);
    chk("midrst_sudi",   SUDI,                     10'h000);
    mr_main_reset = 1'b0;
    step(K285);
    step(D162);
    step(K285);
    step(D162);
    step(K285);
    chk("post_rst_e5", {9'd0, code_sync_status}, 10'd0);
    step(D162);
    chk("post_rst_e6", {9'd0, code_sync_status}, 10'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
